// File: rtl/imm_predecode_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_predecode_buffer: fetch-to-decode FIFO that stores each instruction    |
// | with its pre-extracted immediate and format tag.   Rev 1.0                 |
// +----------------------------------------------------------------------------+
module imm_predecode_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [31:0]              i_in_instr,
  input  logic [XLEN-1:0]          i_in_pc,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [31:0]              o_out_instr,
  output logic [XLEN-1:0]          o_out_pc,
  output logic [XLEN-1:0]          o_out_imm,
  output logic [2:0]               o_out_fmt,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

  localparam logic [2:0] c_FMT_NONE = 3'd0;
  localparam logic [2:0] c_FMT_I    = 3'd1;
  localparam logic [2:0] c_FMT_U    = 3'd2;
  localparam logic [2:0] c_FMT_S    = 3'd3;
  localparam logic [2:0] c_FMT_B    = 3'd4;
  localparam logic [2:0] c_FMT_J    = 3'd5;
  localparam logic [2:0] c_FMT_Z    = 3'd6;

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [31:0]     w_imm32;
  logic [2:0]      w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_push;
  logic            w_pop;

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_instr [0:DEPTH-1];
  logic [XLEN-1:0] r_pc    [0:DEPTH-1];
  logic [XLEN-1:0] r_imm   [0:DEPTH-1];
  logic [2:0]      r_fmt   [0:DEPTH-1];

  assign w_opcode = i_in_instr[6:0];

  // Every format is first built as a 32-bit signed value, then widened.
  always_comb begin
    w_fmt   = c_FMT_NONE;
    w_imm32 = '0;
    case (w_opcode)
      c_OP_IMM, c_OP_IMM32, c_OP_LOAD, c_OP_JALR: begin
        w_fmt   = c_FMT_I;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_fmt   = c_FMT_U;
        w_imm32 = {i_in_instr[31:12], 12'b0};
      end
      c_OP_STORE: begin
        w_fmt   = c_FMT_S;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
      end
      c_OP_BRANCH: begin
        w_fmt   = c_FMT_B;
        w_imm32 = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                   i_in_instr[30:25], i_in_instr[11:8], 1'b0};
      end
      c_OP_JAL: begin
        w_fmt   = c_FMT_J;
        w_imm32 = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                   i_in_instr[20], i_in_instr[30:21], 1'b0};
      end
      c_OP_SYSTEM: begin
        if (i_in_instr[14]) begin
          w_fmt   = c_FMT_Z;
          w_imm32 = {27'b0, i_in_instr[19:15]};
        end
      end
      default: ;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_sext_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_sext_none
      assign w_imm = w_imm32;
    end
  endgenerate

  // in_ready deliberately ignores out_ready: a full buffer never accepts.
  assign o_in_ready  = (r_count < c_DEPTH_CNT);
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid & o_in_ready & ~i_flush;
  assign w_pop       = o_out_valid & i_out_ready & ~i_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_imm[i]   <= '0;
        r_fmt[i]   <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= i_in_instr;
        r_pc[r_wr_ptr]    <= i_in_pc;
        r_imm[r_wr_ptr]   <= w_imm;
        r_fmt[r_wr_ptr]   <= w_fmt;
        r_wr_ptr          <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: ;
      endcase
    end
  end

  assign o_out_instr = r_instr[r_rd_ptr];
  assign o_out_pc    = r_pc[r_rd_ptr];
  assign o_out_imm   = r_imm[r_rd_ptr];
  assign o_out_fmt   = r_fmt[r_rd_ptr];
  assign o_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_predecode_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imm_predecode_buffer: randomized bench with a queue reference model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_imm_predecode_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc, out_imm;
  logic [2:0]  out_fmt, count;

  logic        in_ready32, out_valid32;
  logic [31:0] out_instr32, out_pc32, out_imm32;
  logic [2:0]  out_fmt32, count32;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_predecode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_instr(out_instr), .o_out_pc(out_pc), .o_out_imm(out_imm),
    .o_out_fmt(out_fmt), .o_count(count)
  );

  imm_predecode_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .reset(reset), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready32),
    .i_in_instr(in_instr), .i_in_pc(in_pc[31:0]),
    .o_out_valid(out_valid32), .i_out_ready(out_ready),
    .o_out_instr(out_instr32), .o_out_pc(out_pc32), .o_out_imm(out_imm32),
    .o_out_fmt(out_fmt32), .o_count(count32)
  );

  // Field values reassembled with integer arithmetic, then wrapped to signed.
  function automatic void ref_decode(input logic [31:0] ins,
                                     output logic [2:0] fmt, output logic [63:0] imm);
    longint v = 0;
    fmt = 3'd0;
    case (ins[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        fmt = 3'd1; v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd2; v = longint'(ins[31:12]) * 4096;
        if (v >= longint'(64'h8000_0000)) v -= longint'(64'h1_0000_0000);
      end
      7'b0100011: begin
        fmt = 3'd3; v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        fmt = 3'd4;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'b1101111: begin
        fmt = 3'd5;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'b1110011: begin
        if (ins[14]) begin
          fmt = 3'd6; v = longint'(ins[19:15]);
        end
      end
      default: ;
    endcase
    imm = 64'(v);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
                              7'b0110111, 7'b0010111, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1110011, 7'b0110011};
    logic [31:0] r = $urandom();
    r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  // Advance one clock and apply the same handshake rules to the model queue.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    push = in_valid && (q.size() < DEPTH) && !flush;
    pop  = (q.size() != 0) && out_ready && !flush;
    e.instr = in_instr;
    e.pc    = in_pc;
    ref_decode(in_instr, e.fmt, e.imm);
    @(posedge clk);
    #1;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF0_0093; in_pc = 64'h40;
    cycle(); cycle();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctrl: got count=%0d valid=%b ready=%b, expected 0/0/1", count, out_valid, in_ready);
    end
    vectors++;
    if ({out_instr, out_pc, out_imm, out_fmt} !== '0 || {out_imm32, out_pc32} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got instr=%h pc=%h imm=%h fmt=%0d imm32=%h, expected all zero",
               out_instr, out_pc, out_imm, out_fmt, out_imm32);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] di [8] = '{32'hFFF0_0093, 32'h8000_00B7, 32'hFE00_0EE3, 32'h0040_006F,
                            32'h0011_2623, 32'h3002_D073, 32'h3002_9073, 32'h0000_0073};
    logic [2:0]  df [8] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd0, 3'd0};
    logic [63:0] dm [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                            64'hFFFF_FFFF_FFFF_FFFC, 64'd4, 64'd12, 64'd5, 64'd0, 64'd0};
    logic [63:0] pc;
    for (int k = 0; k < 8; k++) begin
      pc = {$urandom(), $urandom()};
      in_valid = 1'b1; in_instr = di[k]; in_pc = pc; out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_fmt !== df[k] || out_imm !== dm[k] || out_pc !== pc) begin
        miscompares++;
        $display("FAIL decode64[%h]: got valid=%b fmt=%0d imm=%h pc=%h, expected 1 fmt=%0d imm=%h pc=%h",
                 di[k], out_valid, out_fmt, out_imm, out_pc, df[k], dm[k], pc);
      end
      vectors++;
      if (out_imm32 !== dm[k][31:0] || out_fmt32 !== df[k]) begin
        miscompares++;
        $display("FAIL decode32[%h]: got fmt=%0d imm=%h, expected fmt=%0d imm=%h",
                 di[k], out_fmt32, out_imm32, df[k], dm[k][31:0]);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
        miscompares++;
        $display("FAIL decode_pop[%h]: got valid=%b count=%0d, expected 0/0", di[k], out_valid, count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bp [5] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                            32'h0040_0213, 32'h0050_0293};
    int sent = 0, popped = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_instr = bp[sent]; in_pc = 64'h1000 + 64'(4 * sent);
      vectors++;
      if (in_ready !== (c < 4)) begin
        miscompares++;
        $display("FAIL bp_fill_ready[%0d]: got %b expected %b", c, in_ready, (c < 4));
      end
      if (q.size() < DEPTH) sent++;
      cycle();
    end
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_instr !== bp[0]) begin
      miscompares++;
      $display("FAIL bp_full: got count=%0d ready=%b head=%h, expected 4/0/%h", count, in_ready, out_instr, bp[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && (q.size() != 0 || sent < 5); c++) begin
      in_valid = (sent < 5);
      in_instr = bp[(sent < 5) ? sent : 4];
      in_pc    = 64'h1000 + 64'(4 * sent);
      vectors++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL bp_drain_ctrl[%0d]: got count=%0d ready=%b, expected %0d/%b",
                 c, count, in_ready, q.size(), (q.size() < DEPTH));
      end
      if (q.size() != 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== bp[popped]) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: got valid=%b instr=%h, expected 1 %h", popped, out_valid, out_instr, bp[popped]);
        end
        popped++;
      end
      if (in_valid && q.size() < DEPTH) sent++;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (popped != 5 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL bp_done: got popped=%0d count=%0d, expected 5/0", popped, count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = rand_instr(); in_pc = 64'h2000 + 64'(4 * k);
      cycle();
    end
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre: got count=%0d expected 3", count);
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h0070_0393;
    cycle();
    flush = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: got count=%0d valid=%b ready=%b, expected 0/0/1", count, out_valid, in_ready);
    end
    in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hFE00_0EE3; in_pc = 64'h3000;
    cycle();
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd1 || out_instr !== 32'hFE00_0EE3 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFC || out_fmt !== 3'd4) begin
      miscompares++;
      $display("FAIL flush_after: got count=%0d instr=%h imm=%h fmt=%0d, expected 1 fe000ee3 fffffffffffffffc 4",
               count, out_instr, out_imm, out_fmt);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int pv, pr;
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) begin
        reset = 1'b1; in_valid = 1'b1; in_instr = rand_instr();
        cycle();
        reset = 1'b0;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 || out_imm !== 64'd0) begin
          miscompares++;
          $display("FAIL mid_reset: got count=%0d valid=%b instr=%h imm=%h, expected all zero",
                   count, out_valid, out_instr, out_imm);
        end
      end
      pv = ((i / 150) % 2 == 0) ? 75 : 40;
      pr = ((i / 150) % 2 == 0) ? 30 : 80;
      in_valid  = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      flush     = ($urandom_range(0, 99) < 2);
      in_instr  = rand_instr();
      in_pc     = {$urandom(), $urandom()};
      vectors++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: got count=%0d ready=%b valid=%b, expected count=%0d",
                 i, count, in_ready, out_valid, q.size());
      end
      vectors++;
      if (count32 !== 3'(q.size()) || in_ready32 !== (q.size() < DEPTH) || out_valid32 !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_ctrl32[%0d]: got count=%0d ready=%b valid=%b, expected count=%0d",
                 i, count32, in_ready32, out_valid32, q.size());
      end
      if (q.size() != 0) begin
        vectors++;
        if ({out_instr, out_pc, out_imm, out_fmt} !== {q[0].instr, q[0].pc, q[0].imm, q[0].fmt}) begin
          miscompares++;
          $display("FAIL rand_head[%0d]: got %h/%h/%h/%0d, expected %h/%h/%h/%0d", i,
                   out_instr, out_pc, out_imm, out_fmt, q[0].instr, q[0].pc, q[0].imm, q[0].fmt);
        end
        vectors++;
        if ({out_instr32, out_pc32, out_imm32, out_fmt32} !== {q[0].instr, q[0].pc[31:0], q[0].imm[31:0], q[0].fmt}) begin
          miscompares++;
          $display("FAIL rand_head32[%0d]: got %h/%h/%h/%0d, expected %h/%h/%h/%0d", i,
                   out_instr32, out_pc32, out_imm32, out_fmt32, q[0].instr, q[0].pc[31:0], q[0].imm[31:0], q[0].fmt);
        end
      end
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/imm_predecode_buffer.md
# imm_predecode_buffer

Parametrised fetch-to-decode buffer that extracts the immediate and immediate format of each RV32/RV64 instruction when it is enqueued. It then holds the result in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between the fetch stage and the decode stage. Decode receives a ready-made immediate and format tag instead of computing them combinationally. CSR immediates (zimm) are derived internally from the instruction; no external CSR-immediate input exists.

## Interface
- XLEN, 64: datapath width; 32 or 64 only.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch redirect / trap).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes the head entry.
- out_instr  out  32  head raw instruction.
- out_pc  out  XLEN  head PC.
- out_imm  out  XLEN  head immediate.
- out_fmt  out  3  head format: 0 NONE, 1 I, 2 U, 3 S, 4 B, 5 J, 6 Z.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Format selection uses opcode = instr[6:0]:
  - I: 0010011, 0011011, 0000011, 1100111. Immediate is instr[31:20], sign-extended.
  - U: 0110111, 0010111. Immediate is {instr[31:12], 12'b0}, sign-extended from bit 31.
  - S: 0100011. Immediate is {instr[31:25], instr[11:7]}, sign-extended.
  - B: 1100011. Immediate is {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - J: 1101111. Immediate is {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - SYSTEM (1110011) with funct3[2]=1: format Z. Immediate is instr[19:15], zero-extended.
  - SYSTEM with funct3[2]=0, and every other opcode: format NONE, immediate 0.
- All sign extension is to XLEN. With XLEN=32, the U immediate is the 32-bit value unchanged.
- Immediate and format are computed combinationally from in_instr. They are stored in the entry at push, so the output side holds only registered data.
- Push occurs when in_valid & in_ready & !flush. Pop occurs when out_valid & out_ready & !flush.
- in_ready = (count < DEPTH). It has no combinational dependence on out_ready, so a full buffer does not accept a push even when a pop happens in the same cycle.
- out_valid = (count != 0). out_instr, out_pc, out_imm and out_fmt reflect the entry at the read pointer.
- Simultaneous push and pop leaves count unchanged; both pointers advance.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush clears count and both pointers at the next edge. A push or pop requested in the flush cycle is dropped.
- flush takes priority over push and pop; reset takes priority over flush.

## Timing
- Reset values:
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - out_instr=0, out_pc=0, out_imm=0, out_fmt=0 (entry storage cleared).
- Latency: an instruction accepted at edge N is visible with out_valid=1 after edge N (one cycle) when the buffer was empty.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Output payload stays stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: at the next edge, all state returns to reset values and in-flight entries are lost.
- out_* signals while out_valid=0 are don't-care, except immediately after reset.

## Test plan
- addi x1,x0,-1 (0xFFF00093), XLEN=64 → after 1 cycle: out_valid=1, out_fmt=1, out_imm=0xFFFFFFFFFFFFFFFF. lui (0x800000B7) → out_fmt=2, out_imm=0xFFFFFFFF80000000. With XLEN=32 the same lui gives out_imm=0x80000000.
- beq x0,x0,-4 (0xFE000EE3) → out_fmt=4, out_imm=-4. jal x0,4 (0x0040006F) → out_fmt=5, out_imm=4. sw (0x00112623) → out_fmt=3, out_imm=12.
- csrrwi x0,0x300,5 (0x3002D073) → out_fmt=6, out_imm=5. csrrw (0x30029073) → out_fmt=0, out_imm=0. ecall (0x00000073) → out_fmt=0, out_imm=0.
- Backpressure with out_ready=0: push 5 instructions with DEPTH=4 → in_ready drops after the 4th, count=4, 5th held by fetch. Then out_ready=1 → entries drain in order, count decrements each cycle, and in_ready returns the cycle after the first pop.
- With count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, and neither the flush-cycle push nor the pop takes effect. A subsequent push appears at the head with its own immediate.
- Random push/pop over ≥ 1000 cycles with pointer wrap, checked against a reference queue → identical payload order and count. Reset asserted mid-stream → count=0 and out_valid=0 next cycle.
